mux_arbiter: RTL

- Two-requester round-robin arbiter that shares the 32-bit 2x1 mux between source A and source B, for example a rasteriser pixel stream and a fill-engine stream, and drives a single downstream pixel/command bus.
- Grants are held per packet, from the first beat through the beat flagged last.
- Drives the mux select, gates the valid/ready handshakes, and runs a stall watchdog that revokes a grant whose owner stops sending mid-packet.

---
 rtl/gpu_arb_pkg.sv | 16 +
 rtl/mux_arbiter_mux.sv | 16 +
 rtl/mux_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gpu_arb_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
package gpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // Mux select encoding: 1 routes source A, 0 routes source B.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mux_arbiter_mux.sv
// 2:1 data mux shared between source A and source B.
module mux_arbiter_mux #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    // sel_i = 1 routes a_i, sel_i = 0 routes b_i.
    always_comb begin
        y_o = sel_i ? a_i : b_i;
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter in front of the shared 2:1 data mux.
// Grants are held for a whole packet; a watchdog revokes a grant whose
// owner stops presenting beats mid-packet.
module mux_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              mux_sel,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    // The revoke fires on the cycle the count would reach TIMEOUT, so the
    // stored value never exceeds TIMEOUT-1 and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mux_sel_q, mux_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_hit;
    logic              cur_valid;
    logic              cur_last;
    logic [DATA_W-1:0] mux_y;

    // Data path select comes straight from a flop so it is stable all cycle.
    mux_arbiter_mux #(
        .DATA_W(DATA_W)
    ) u_mux (
        .sel_i (mux_sel_q),
        .a_i   (a_data),
        .b_i   (b_data),
        .y_o   (mux_y)
    );

    assign mux_sel = mux_sel_q;

    // State, round-robin pointer, select and watchdog registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_B;
            mux_sel_q    <= SEL_A;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mux_sel_q    <= mux_sel_d;
            cnt_q        <= cnt_d;
        end
    end

    // Handshake of whichever source currently owns the grant.
    always_comb begin
        cur_valid = (state_q == GRANT_A) ? a_valid : b_valid;
        cur_last  = (state_q == GRANT_A) ? a_last  : b_last;
    end

    // Arbitration, packet-end detection and stall watchdog.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mux_sel_d    = mux_sel_q;
        cnt_d        = cnt_q;
        timeout_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (a_valid && (!b_valid || last_grant_q == SEL_B)) begin
                    state_d   = GRANT_A;
                    mux_sel_d = SEL_A;
                end else if (b_valid) begin
                    state_d   = GRANT_B;
                    mux_sel_d = SEL_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (cur_valid) begin
                    cnt_d = '0;
                    if (out_ready && cur_last) begin
                        state_d      = IDLE;
                        last_grant_d = (state_q == GRANT_A) ? SEL_A : SEL_B;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit  = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                    last_grant_d = (state_q == GRANT_A) ? SEL_A : SEL_B;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake gating and downstream outputs; everything is quiet in IDLE.
    always_comb begin
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        timeout_err = timeout_hit;
        case (state_q)
            GRANT_A: begin
                busy      = 1'b1;
                out_valid = a_valid;
                out_last  = a_last;
                out_data  = mux_y;
                a_ready   = out_ready;
            end
            GRANT_B: begin
                busy      = 1'b1;
                out_valid = b_valid;
                out_last  = b_last;
                out_data  = mux_y;
                b_ready   = out_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
